// File: rtl/debounce_pulso_acao.sv
// debounce_pulso_acao: action-key conditioner for the 8-bit ALU board.
// The raw key goes through a 2-flop synchroniser and a 4-state debounce FSM.
// The block emits one registered action_pulso for each confirmed press.
// Optional auto-repeat while the key is held: define DEBOUNCE_PULSO_AUTOREPEAT_EN.
module debounce_pulso_acao #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int KEY_ACTIVE_LOW  = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_in,
  output logic       action_pulso,
  output logic       key_estavel,
  output logic [7:0] contagem_pulsos
);

  localparam int             CW      = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  // Synchroniser level that means "not pressed".
  localparam logic           REL     = (KEY_ACTIVE_LOW != 0);

  // Reject parameter values the debounce and repeat counters cannot honour.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 2) begin : g_bad_param
    $error("debounce_pulso_acao: illegal parameter value");
  end

  typedef enum logic [1:0] {SOLTO, CONF_PRESS, PRESSIONADO, CONF_SOLTA} state_t;

  state_t        state_q;
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          fire_q;
  logic          pulso_q;
  logic          estavel_q;
  logic [7:0]    contagem_q;
  logic          pressed_s;

  // sync_q[1] is the second synchroniser stage; nothing looks at key_in directly.
  assign pressed_s = sync_q[1] ^ REL;

`ifdef DEBOUNCE_PULSO_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 2) ? $clog2(RMAX) : 1;

  logic [RW-1:0] rpt_q;
  logic          rpt_first_q;
  logic          rpt_hit;

  // First repeat waits REPEAT_DELAY cycles in PRESSIONADO; later repeats wait REPEAT_PERIOD cycles.
  assign rpt_hit = rpt_first_q ? (rpt_q == RW'(REPEAT_DELAY - 1))
                               : (rpt_q == RW'(REPEAT_PERIOD - 1));
`endif

  // Synchroniser, debounce FSM, and the registered outputs.
  // fire_q marks the edge where a pulse is earned.
  // pulso_q follows it one cycle later, which sets the press-to-pulse latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= {2{REL}};
      state_q     <= SOLTO;
      cnt_q       <= '0;
      fire_q      <= 1'b0;
      pulso_q     <= 1'b0;
      estavel_q   <= 1'b0;
      contagem_q  <= 8'd0;
`ifdef DEBOUNCE_PULSO_AUTOREPEAT_EN
      rpt_q       <= '0;
      rpt_first_q <= 1'b1;
`endif
    end else begin
      sync_q  <= {sync_q[0], key_in};
      fire_q  <= 1'b0;
      pulso_q <= fire_q;
      if (fire_q) contagem_q <= contagem_q + 8'd1;

      case (state_q)
        SOLTO: begin
          if (pressed_s) begin
            state_q <= CONF_PRESS;
            cnt_q   <= '0;
          end
        end

        CONF_PRESS: begin
          if (!pressed_s) begin
            state_q <= SOLTO;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_MAX) begin
            state_q     <= PRESSIONADO;
            cnt_q       <= '0;
            estavel_q   <= 1'b1;
            fire_q      <= 1'b1;
`ifdef DEBOUNCE_PULSO_AUTOREPEAT_EN
            rpt_q       <= '0;
            rpt_first_q <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        PRESSIONADO: begin
          if (!pressed_s) begin
            state_q     <= CONF_SOLTA;
            cnt_q       <= '0;
`ifdef DEBOUNCE_PULSO_AUTOREPEAT_EN
            rpt_q       <= '0;
            rpt_first_q <= 1'b1;
          end else if (rpt_hit) begin
            fire_q      <= 1'b1;
            rpt_q       <= '0;
            rpt_first_q <= 1'b0;
          end else begin
            rpt_q       <= rpt_q + RW'(1);
`endif
          end
        end

        CONF_SOLTA: begin
          if (pressed_s) begin
            // A bounce during release returns to held without a new pulse.
            state_q     <= PRESSIONADO;
            cnt_q       <= '0;
`ifdef DEBOUNCE_PULSO_AUTOREPEAT_EN
            rpt_q       <= '0;
            rpt_first_q <= 1'b1;
`endif
          end else if (cnt_q == CNT_MAX) begin
            state_q   <= SOLTO;
            cnt_q     <= '0;
            estavel_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  assign action_pulso    = pulso_q;
  assign key_estavel     = estavel_q;
  assign contagem_pulsos = contagem_q;

endmodule
